branch_ctrl: RTL and testbench

Branch-resolution controller for the RV32I pipeline's EX stage. It accepts one conditional branch at a time from decode and registers its operands. It drives the shared branch comparator (the `cmp` block) from those registers and samples its `br_en` result. It checks the outcome against the fetch-stage prediction and, on a mispredict, issues a held redirect with a one-cycle flush; a mispredict counter and an optional 2-bit branch history table (BHT) complete the block.

---
 rtl/rv32i_types.sv | 25 ++
 rtl/bht_2bit.sv | 41 ++++
 rtl/branch_ctrl.sv | 140 ++++++++++++++
 tb/tb_branch_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I types: branch compare operations, branch controller states, BHT init value.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv32i_types;

    // Branch compare operation, encoded as the instruction's funct3 field.
    typedef enum logic [2:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_BLT  = 3'b100,
        BR_BGE  = 3'b101,
        BR_BLTU = 3'b110,
        BR_BGEU = 3'b111
    } branch_funct3_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RESOLVE  = 2'd1,
        REDIRECT = 2'd2
    } branch_ctrl_state_t;

    // BHT counters start weakly not-taken.
    localparam logic [1:0] BHT_INIT = 2'b01;

endpackage

// File: rtl/bht_2bit.sv
// Branch history table of 2-bit saturating counters.
// Latency: lookup is combinational; an update is visible the cycle after it is written (no bypass).
// Backpressure: none, one lookup and one update per cycle.
// Ports: clk/rst (sync, active-high); lookup_idx -> pred_taken;
//        upd_valid/upd_idx/upd_taken train one counter per cycle.
module bht_2bit
    import rv32i_types::*;
#(
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] lookup_idx,
    output logic             pred_taken,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    localparam int ENTRIES = 1 << IDX_W;

    logic [1:0] cnt_q [ENTRIES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                cnt_q[i] <= BHT_INIT;
            end
        end else if (upd_valid) begin
            if (upd_taken && (cnt_q[upd_idx] != 2'b11)) begin
                cnt_q[upd_idx] <= cnt_q[upd_idx] + 2'b01;
            end else if (!upd_taken && (cnt_q[upd_idx] != 2'b00)) begin
                cnt_q[upd_idx] <= cnt_q[upd_idx] - 2'b01;
            end
        end
    end

    // Reads the registered counter, so a same-cycle update is not seen yet.
    assign pred_taken = cnt_q[lookup_idx][1];

endmodule

// File: rtl/branch_ctrl.sv
// EX-stage branch resolution: latches one branch, drives the comparator, checks the prediction, redirects on mispredict.
// Latency: resolve one cycle after accept; on mispredict redirect_valid rises the cycle after resolve.
// Backpressure: id_ready drops on mispredict and through REDIRECT; redirect held until redirect_ready.
// Ports: id_* from decode (valid/ready); cmp_* to / cmp_br_en from the external comparator;
//        fetch_pc -> fetch_pred_taken; redirect_* and flush to fetch; resolved_*, mispredict_cnt status.
// Option: define BRANCH_PRED_EN to add the 2-bit BHT; otherwise fetch_pred_taken is static not-taken.
module branch_ctrl
    import rv32i_types::*;
#(
    parameter int BHT_IDX_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    output logic        id_ready,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_target,
    input  logic [31:0] id_rs1,
    input  logic [31:0] id_cmpmux,
    input  logic [2:0]  id_funct3,
    input  logic        id_pred_taken,
    output logic [31:0] cmp_rs1,
    output logic [31:0] cmp_cmpmux,
    output logic [2:0]  cmp_op,
    input  logic        cmp_br_en,
    input  logic [31:0] fetch_pc,
    output logic        fetch_pred_taken,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready,
    output logic        flush,
    output logic        resolved_valid,
    output logic        resolved_taken,
    output logic [31:0] mispredict_cnt
);

    branch_ctrl_state_t state_q, state_d;

    // EX register
    logic [31:0] pc_q, target_q, rs1_q, cmpmux_q;
    logic [2:0]  funct3_q;
    logic        pred_q;

    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic [31:0] mispredict_cnt_q, mispredict_cnt_d;

    logic in_resolve;
    logic mispredict;
    logic accept;

    assign in_resolve = (state_q == RESOLVE);
    assign mispredict = in_resolve && (cmp_br_en != pred_q);
    assign id_ready   = (state_q == IDLE) || (in_resolve && !mispredict);
    assign accept     = id_valid && id_ready;

    assign cmp_rs1    = rs1_q;
    assign cmp_cmpmux = cmpmux_q;
    assign cmp_op     = funct3_q;

    assign resolved_valid = in_resolve;
    assign resolved_taken = in_resolve && cmp_br_en;

    // Gated by rst so a reset landing in REDIRECT never lets fetch see a redirect or flush.
    assign redirect_valid = (state_q == REDIRECT) && !rst;
    assign flush          = redirect_valid && redirect_ready;
    assign redirect_pc    = redirect_pc_q;
    assign mispredict_cnt = mispredict_cnt_q;

    always_comb begin
        state_d          = state_q;
        redirect_pc_d    = redirect_pc_q;
        mispredict_cnt_d = mispredict_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (id_valid) state_d = RESOLVE;
            end
            RESOLVE: begin
                if (mispredict) begin
                    // Wrong path: go to the target if taken, else fall through (wraps at 2^32).
                    redirect_pc_d    = cmp_br_en ? target_q : (pc_q + 32'd4);
                    mispredict_cnt_d = mispredict_cnt_q + 32'd1;
                    state_d          = REDIRECT;
                end else if (!id_valid) begin
                    state_d = IDLE;
                end
            end
            REDIRECT: begin
                if (redirect_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            pc_q             <= '0;
            target_q         <= '0;
            rs1_q            <= '0;
            cmpmux_q         <= '0;
            funct3_q         <= '0;
            pred_q           <= 1'b0;
            redirect_pc_q    <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            state_q          <= state_d;
            redirect_pc_q    <= redirect_pc_d;
            mispredict_cnt_q <= mispredict_cnt_d;
            if (accept) begin
                pc_q     <= id_pc;
                target_q <= id_target;
                rs1_q    <= id_rs1;
                cmpmux_q <= id_cmpmux;
                funct3_q <= id_funct3;
                pred_q   <= id_pred_taken;
            end
        end
    end

    // Only a slice of fetch_pc indexes the BHT, and none of it is used without one.
    logic unused_fetch_pc;
    assign unused_fetch_pc = ^fetch_pc;

`ifdef BRANCH_PRED_EN
    bht_2bit #(
        .IDX_W (BHT_IDX_W)
    ) u_bht (
        .clk        (clk),
        .rst        (rst),
        .lookup_idx (fetch_pc[BHT_IDX_W+1:2]),
        .pred_taken (fetch_pred_taken),
        .upd_valid  (resolved_valid),
        .upd_idx    (pc_q[BHT_IDX_W+1:2]),
        .upd_taken  (cmp_br_en)
    );
`else
    assign fetch_pred_taken = 1'b0;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
module tb_branch_ctrl;
    import rv32i_types::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc, id_target, id_rs1, id_cmpmux;
    logic [2:0]  id_funct3;
    logic        id_pred_taken;
    logic [31:0] cmp_rs1, cmp_cmpmux;
    logic [2:0]  cmp_op;
    logic        cmp_br_en;
    logic [31:0] fetch_pc;
    logic        fetch_pred_taken;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;
    logic        flush;
    logic        resolved_valid;
    logic        resolved_taken;
    logic [31:0] mispredict_cnt;

    branch_ctrl #(.BHT_IDX_W(6)) dut (
        .clk              (clk),
        .rst              (rst),
        .id_valid         (id_valid),
        .id_ready         (id_ready),
        .id_pc            (id_pc),
        .id_target        (id_target),
        .id_rs1           (id_rs1),
        .id_cmpmux        (id_cmpmux),
        .id_funct3        (id_funct3),
        .id_pred_taken    (id_pred_taken),
        .cmp_rs1          (cmp_rs1),
        .cmp_cmpmux       (cmp_cmpmux),
        .cmp_op           (cmp_op),
        .cmp_br_en        (cmp_br_en),
        .fetch_pc         (fetch_pc),
        .fetch_pred_taken (fetch_pred_taken),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .redirect_ready   (redirect_ready),
        .flush            (flush),
        .resolved_valid   (resolved_valid),
        .resolved_taken   (resolved_taken),
        .mispredict_cnt   (mispredict_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural model of the external comparator.
    always_comb begin
        case (cmp_op)
            3'b000:  cmp_br_en = (cmp_rs1 == cmp_cmpmux);
            3'b001:  cmp_br_en = (cmp_rs1 != cmp_cmpmux);
            3'b100:  cmp_br_en = ($signed(cmp_rs1) <  $signed(cmp_cmpmux));
            3'b101:  cmp_br_en = ($signed(cmp_rs1) >= $signed(cmp_cmpmux));
            3'b110:  cmp_br_en = (cmp_rs1 <  cmp_cmpmux);
            3'b111:  cmp_br_en = (cmp_rs1 >= cmp_cmpmux);
            default: cmp_br_en = 1'b0;
        endcase
    end

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] rs1;
        logic [31:0] cmpmux;
        logic [31:0] pc;
        logic [31:0] target;
        logic        pred;
        logic        exp_taken;
        logic [31:0] exp_rpc;
        int          hold;
    } vec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   model_cnt = 0;
    logic sb_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Scoreboard: each resolve pulse must match the oldest accepted branch.
    always @(negedge clk) begin
        if (!rst && resolved_valid) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_resolve", 32'd1, 32'd0);
            end else begin
                logic e;
                e = sb_q.pop_front();
                chk("resolved_taken", {31'd0, resolved_taken}, {31'd0, e});
                chk("no_redirect_in_resolve", {31'd0, redirect_valid}, 32'd0);
            end
        end
    end

    // Called and returns at a negedge.
    task automatic run_branch(input vec_t v);
        int  guard;
        logic mis;
        guard = 0;
        while (!id_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!id_ready) chk("id_ready_timeout", 32'd0, 32'd1);
        id_valid      = 1'b1;
        id_funct3     = v.f3;
        id_rs1        = v.rs1;
        id_cmpmux     = v.cmpmux;
        id_pc         = v.pc;
        id_target     = v.target;
        id_pred_taken = v.pred;
        @(posedge clk);
        sb_q.push_back(v.exp_taken);
        mis = (v.exp_taken != v.pred);
        @(negedge clk);
        id_valid = 1'b0;
        chk("id_ready_resolve", {31'd0, id_ready}, {31'd0, !mis});
        if (mis) begin
            model_cnt++;
            @(negedge clk);
            chk("redir_valid", {31'd0, redirect_valid}, 32'd1);
            chk("redir_pc", redirect_pc, v.exp_rpc);
            chk("mispredict_cnt", mispredict_cnt, model_cnt);
            for (int h = 0; h < v.hold; h++) begin
                @(negedge clk);
                chk("hold_valid", {31'd0, redirect_valid}, 32'd1);
                chk("hold_pc", redirect_pc, v.exp_rpc);
                chk("hold_id_ready", {31'd0, id_ready}, 32'd0);
                chk("hold_flush", {31'd0, flush}, 32'd0);
            end
            redirect_ready = 1'b1;
            #1;
            chk("flush_on_ready", {31'd0, flush}, 32'd1);
            @(negedge clk);
            redirect_ready = 1'b0;
            chk("after_redir_valid", {31'd0, redirect_valid}, 32'd0);
            chk("after_redir_flush", {31'd0, flush}, 32'd0);
            chk("after_redir_idle", {31'd0, id_ready}, 32'd1);
        end else begin
            @(negedge clk);
            chk("no_redirect", {31'd0, redirect_valid}, 32'd0);
            chk("cnt_unchanged", mispredict_cnt, model_cnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, want completion");
        $fatal(1);
    end

    initial begin
        vec_t vecs[9];
        vec_t b2b[4];
        vec_t t;

        vecs[0] = '{BR_BEQ,  32'd5,        32'd6,        32'h200,      32'h300, 1'b0, 1'b0, 32'h0,  0};
        vecs[1] = '{BR_BLT,  32'hFFFFFFFF, 32'd1,        32'h100,      32'h80,  1'b0, 1'b1, 32'h80, 3};
        vecs[2] = '{BR_BGEU, 32'd1,        32'hFFFFFFFF, 32'hFFFFFFFC, 32'h40,  1'b1, 1'b0, 32'h0,  0};
        vecs[3] = '{BR_BNE,  32'd7,        32'd7,        32'h10,       32'h20,  1'b0, 1'b0, 32'h0,  0};
        vecs[4] = '{BR_BNE,  32'd7,        32'd8,        32'h14,       32'h24,  1'b1, 1'b1, 32'h0,  0};
        vecs[5] = '{BR_BGE,  32'h80000000, 32'h7FFFFFFF, 32'h30,       32'h50,  1'b1, 1'b0, 32'h34, 1};
        vecs[6] = '{BR_BLTU, 32'h7FFFFFFF, 32'h80000000, 32'h60,       32'h90,  1'b0, 1'b1, 32'h90, 0};
        vecs[7] = '{3'b010,  32'd3,        32'd3,        32'h70,       32'h99,  1'b1, 1'b0, 32'h74, 0};
        vecs[8] = '{BR_BEQ,  32'd9,        32'd9,        32'h80,       32'h88,  1'b1, 1'b1, 32'h0,  0};

        b2b[0] = '{BR_BEQ,  32'd1, 32'd1, 32'h400, 32'h600, 1'b1, 1'b1, 32'h0,   0};
        b2b[1] = '{BR_BNE,  32'd1, 32'd2, 32'h404, 32'h604, 1'b1, 1'b1, 32'h0,   0};
        b2b[2] = '{BR_BLTU, 32'd5, 32'd3, 32'h408, 32'h608, 1'b0, 1'b0, 32'h0,   0};
        b2b[3] = '{BR_BEQ,  32'd4, 32'd4, 32'h40C, 32'h500, 1'b0, 1'b1, 32'h500, 0};

        rst = 1'b1; id_valid = 1'b0; id_pc = '0; id_target = '0; id_rs1 = '0;
        id_cmpmux = '0; id_funct3 = '0; id_pred_taken = 1'b0; redirect_ready = 1'b0;
        fetch_pc = 32'h40;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_id_ready", {31'd0, id_ready}, 32'd1);
        chk("rst_redir_valid", {31'd0, redirect_valid}, 32'd0);
        chk("rst_redir_pc", redirect_pc, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_resolved", {30'd0, resolved_valid, resolved_taken}, 32'd0);
        chk("rst_cnt", mispredict_cnt, 32'd0);
        chk("rst_cmp", {cmp_rs1 | cmp_cmpmux} | {29'd0, cmp_op}, 32'd0);
        chk("rst_fetch_pred", {31'd0, fetch_pred_taken}, 32'd0);

        for (int i = 0; i < 9; i++) run_branch(vecs[i]);

        // Back-to-back correct predictions, then a mispredict aborted by reset in REDIRECT.
        id_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            id_funct3 = b2b[i].f3; id_rs1 = b2b[i].rs1; id_cmpmux = b2b[i].cmpmux;
            id_pc = b2b[i].pc; id_target = b2b[i].target; id_pred_taken = b2b[i].pred;
            @(posedge clk);
            sb_q.push_back(b2b[i].exp_taken);
            @(negedge clk);
            chk("b2b_resolved_valid", {31'd0, resolved_valid}, 32'd1);
            chk("b2b_id_ready", {31'd0, id_ready}, (i < 3) ? 32'd1 : 32'd0);
        end
        id_valid = 1'b0;
        model_cnt++;
        @(negedge clk);
        chk("b2b_redir_valid", {31'd0, redirect_valid}, 32'd1);
        chk("b2b_redir_pc", redirect_pc, 32'h500);
        chk("b2b_cnt", mispredict_cnt, model_cnt);
        rst = 1'b1;
        redirect_ready = 1'b1;
        #1;
        chk("rst_abort_flush", {31'd0, flush}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        redirect_ready = 1'b0;
        model_cnt = 0;
        chk("abort_redir_valid", {31'd0, redirect_valid}, 32'd0);
        chk("abort_idle", {31'd0, id_ready}, 32'd1);
        chk("abort_resolved", {31'd0, resolved_valid}, 32'd0);
        chk("abort_cnt", mispredict_cnt, 32'd0);
        chk("abort_ex_cleared", cmp_rs1, 32'd0);
        @(negedge clk);
        chk("abort_no_flush", {31'd0, flush}, 32'd0);
        chk("abort_still_idle", {31'd0, redirect_valid}, 32'd0);

`ifdef BRANCH_PRED_EN
        fetch_pc = 32'h40;
        #1;
        chk("bht_init", {31'd0, fetch_pred_taken}, 32'd0);
        t = '{BR_BEQ, 32'd3, 32'd3, 32'h40, 32'h60, 1'b0, 1'b1, 32'h60, 0};
        run_branch(t);
        chk("bht_after_1", {31'd0, fetch_pred_taken}, 32'd1);
        t.pred = 1'b1;
        run_branch(t);
        chk("bht_after_2", {31'd0, fetch_pred_taken}, 32'd1);
        run_branch(t);
        chk("bht_after_3", {31'd0, fetch_pred_taken}, 32'd1);
        // From a saturated 11, one not-taken keeps the prediction; a second clears it.
        t = '{BR_BEQ, 32'd3, 32'd4, 32'h40, 32'h60, 1'b1, 1'b0, 32'h44, 0};
        run_branch(t);
        chk("bht_sat_dec1", {31'd0, fetch_pred_taken}, 32'd1);
        t.pred = 1'b0;
        run_branch(t);
        chk("bht_sat_dec2", {31'd0, fetch_pred_taken}, 32'd0);
`else
        t = '{BR_BEQ, 32'd3, 32'd3, 32'h40, 32'h60, 1'b0, 1'b1, 32'h60, 0};
        run_branch(t);
        fetch_pc = 32'h40;
        #1;
        chk("static_pred_40", {31'd0, fetch_pred_taken}, 32'd0);
        fetch_pc = 32'h100;
        #1;
        chk("static_pred_100", {31'd0, fetch_pred_taken}, 32'd0);
`endif

        chk("sb_drained", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
